cdc_handshake_tx: RTL and testbench

Source-domain transmitter of a four-phase req/ack clock-domain-crossing handshake. It moves one DATA_W-bit word per transaction to a destination-domain receiver. It accepts a word with a valid/ready handshake, holds it stable on xfer_data, and raises xfer_req. It synchronizes the returning xfer_ack with an internal dual-rank synchronizer and completes the req-high/ack-high/req-low/ack-low sequence before accepting the next word.

---
 rtl/cdc_handshake_tx_pkg.sv | 27 ++
 rtl/cdc_handshake_tx_if.sv | 28 ++
 rtl/cdc_handshake_tx_sync.sv | 25 ++
 rtl/cdc_handshake_tx.sv | 140 ++++++++++++++
 tb/tb_cdc_handshake_tx.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/cdc_handshake_tx_pkg.sv
// cdc_handshake_tx_pkg
//   Shared definitions for the req/ack CDC transmitter: FSM state encoding,
//   the minimum synchronizer depth, and a clog2 helper for counter widths.
//   No ports (package).
package cdc_handshake_tx_pkg;

  // Fewer than two ranks does not give metastability protection.
  localparam int unsigned CDC_LEN_MIN = 2;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_IDLE    = 2'd1,
    ST_WAIT_HI = 2'd2,
    ST_WAIT_LO = 2'd3
  } cdc_state_e;

  // Smallest r such that 2**r >= v.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(v)) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cdc_handshake_tx_if.sv
// cdc_handshake_tx_if
//   Bundle of the upstream valid/ready word interface, the cross-domain
//   req/ack/data signals and the status/control signals of cdc_handshake_tx.
//   master : the transmitter (drives in_ready, xfer_req, xfer_data, done, err)
//   slave  : its environment (drives in_valid, in_data, xfer_ack, err_clr)
interface cdc_handshake_tx_if #(
  parameter int unsigned DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              xfer_req;
  logic [DATA_W-1:0] xfer_data;
  logic              xfer_ack;
  logic              done;
  logic              err;
  logic              err_clr;

  modport master (
    input  in_valid, in_data, xfer_ack, err_clr,
    output in_ready, xfer_req, xfer_data, done, err
  );

  modport slave (
    output in_valid, in_data, xfer_ack, err_clr,
    input  in_ready, xfer_req, xfer_data, done, err
  );
endinterface

// File: rtl/cdc_handshake_tx_sync.sv
// cdc_handshake_tx_sync
//   Multi-rank single-bit synchronizer; output lags input by STAGES edges.
//   clk  : destination clock
//   rst  : asynchronous active-high reset, clears all ranks to 0
//   d_i  : asynchronous input bit
//   q_o  : synchronized bit
module cdc_handshake_tx_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// cdc_handshake_tx
//   Source side of a four-phase req/ack clock-domain crossing. Accepts one
//   word via valid/ready, holds it on xfer_data, raises xfer_req, and waits
//   for the synchronized ack to rise then fall before taking the next word.
//   clk, rst          : source clock, asynchronous active-high reset
//   hs.in_valid/ready : upstream handshake (in_ready is a registered decode)
//   hs.in_data        : upstream word
//   hs.xfer_req/data  : to destination domain, straight from flops
//   hs.xfer_ack       : from destination domain, synchronized before use
//   hs.done           : one-cycle pulse when ack is seen low again
//   hs.err / err_clr  : sticky ack-timeout flag and its synchronous clear
module cdc_handshake_tx
  import cdc_handshake_tx_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned CDC_LEN     = 2,
  parameter int unsigned TIMEOUT_CYC = 0
) (
  input logic               clk,
  input logic               rst,
  cdc_handshake_tx_if.master hs
);

  localparam int unsigned SYNC_LEN   = (CDC_LEN < CDC_LEN_MIN) ? CDC_LEN_MIN : CDC_LEN;
  localparam int unsigned INIT_W     = clog2(SYNC_LEN + 1);
  localparam int unsigned WAIT_W     = (TIMEOUT_CYC == 0) ? 1 : clog2(TIMEOUT_CYC + 1);
  localparam logic [INIT_W-1:0] INIT_DONE = INIT_W'(SYNC_LEN);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT_CYC);
  localparam logic              TIMEOUT_EN = (TIMEOUT_CYC != 0);

  logic ack_s;

  cdc_handshake_tx_sync #(
    .STAGES (SYNC_LEN)
  ) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d_i (hs.xfer_ack),
    .q_o (ack_s)
  );

  cdc_state_e        state_q,    state_d;
  logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              req_q,      req_d;
  logic [DATA_W-1:0] data_q,     data_d;
  logic              ready_q,    ready_d;
  logic              done_q,     done_d;
  logic              err_q,      err_d;
  logic              wait_adv;
  logic              tmo_hit;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    wait_cnt_d = wait_cnt_q;
    req_d      = req_q;
    data_d     = data_q;
    done_d     = 1'b0;
    wait_adv   = 1'b0;
    tmo_hit    = 1'b0;

    unique case (state_q)
      // Wait out the synchronizer fill and insist ack is low, so a reset
      // during a transaction cannot overlap the destination's old ack.
      ST_INIT: begin
        if (init_cnt_q != INIT_DONE) init_cnt_d = init_cnt_q + INIT_W'(1);
        else if (!ack_s)             state_d    = ST_IDLE;
      end
      // A stray ack here is a protocol violation and is simply ignored.
      ST_IDLE: begin
        if (hs.in_valid) begin
          data_d     = hs.in_data;
          req_d      = 1'b1;
          wait_cnt_d = '0;
          state_d    = ST_WAIT_HI;
        end
      end
      ST_WAIT_HI: begin
        if (ack_s) begin
          req_d      = 1'b0;
          wait_cnt_d = '0;
          state_d    = ST_WAIT_LO;
        end else begin
          wait_adv = 1'b1;
        end
      end
      ST_WAIT_LO: begin
        if (!ack_s) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wait_adv = 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase

    // Timeout only flags; the FSM keeps waiting so req/ack stay paired.
    if (TIMEOUT_EN && wait_adv && (wait_cnt_q != WAIT_MAX)) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      tmo_hit    = (wait_cnt_d == WAIT_MAX);
    end

    if (tmo_hit)         err_d = 1'b1;
    else if (hs.err_clr) err_d = 1'b0;
    else                 err_d = err_q;

    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      wait_cnt_q <= '0;
      req_q      <= 1'b0;
      data_q     <= '0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      req_q      <= req_d;
      data_q     <= data_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign hs.in_ready  = ready_q;
  assign hs.xfer_req  = req_q;
  assign hs.xfer_data = data_q;
  assign hs.done      = done_q;
  assign hs.err       = err_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// tb_cdc_handshake_tx
//   Directed bench for cdc_handshake_tx (DATA_W=32, CDC_LEN=2, TIMEOUT_CYC=16).
//   Inputs change 1 time unit after a rising edge; outputs are sampled there.
module tb_cdc_handshake_tx;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  int   done_cnt;
  int   rise_cnt;
  logic req_prev;

  cdc_handshake_tx_if #(.DATA_W(32)) hs ();

  cdc_handshake_tx #(
    .DATA_W      (32),
    .CDC_LEN     (2),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hs  (hs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event counters observed on each rising edge (pre-edge values).
  initial begin
    done_cnt = 0;
    rise_cnt = 0;
    req_prev = 1'b0;
  end
  always @(posedge clk) begin
    if (hs.done === 1'b1) done_cnt = done_cnt + 1;
    if (hs.xfer_req === 1'b1 && req_prev !== 1'b1) rise_cnt = rise_cnt + 1;
    req_prev = hs.xfer_req;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag, input logic lvl);
    int n;
    n = 0;
    while (hs.xfer_req !== lvl && n < 50) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(hs.xfer_req), 32'(lvl));
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (hs.done !== 1'b1 && n < 50) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(hs.done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int d0;
    int r0;
    n_vec = 0;
    n_err = 0;
    rst         = 1'b1;
    hs.in_valid = 1'b0;
    hs.in_data  = '0;
    hs.xfer_ack = 1'b0;
    hs.err_clr  = 1'b0;

    // Reset state and INIT wait
    tick(3);
    chk("rst_ready", 32'(hs.in_ready), 32'd0);
    chk("rst_req",   32'(hs.xfer_req), 32'd0);
    chk("rst_data",  hs.xfer_data,     32'd0);
    chk("rst_done",  32'(hs.done),     32'd0);
    chk("rst_err",   32'(hs.err),      32'd0);
    rst = 1'b0;
    tick(1);
    chk("init_e1_ready", 32'(hs.in_ready), 32'd0);
    tick(1);
    chk("init_e2_ready", 32'(hs.in_ready), 32'd0);
    tick(1);
    chk("init_e3_ready", 32'(hs.in_ready), 32'd1);
    chk("init_req",      32'(hs.xfer_req), 32'd0);
    chk("init_data",     hs.xfer_data,     32'd0);

    // Single transaction
    d0 = done_cnt;
    hs.in_valid = 1'b1;
    hs.in_data  = 32'hDEADBEEF;
    tick(1);
    chk("acc_req",   32'(hs.xfer_req), 32'd1);
    chk("acc_data",  hs.xfer_data,     32'hDEADBEEF);
    chk("acc_ready", 32'(hs.in_ready), 32'd0);
    hs.in_valid = 1'b0;
    hs.in_data  = 32'h12345678;
    tick(3);
    chk("hold_data", hs.xfer_data, 32'hDEADBEEF);
    hs.xfer_ack = 1'b1;
    tick(1);
    chk("ack1_req", 32'(hs.xfer_req), 32'd1);
    tick(2);
    chk("ack3_req",  32'(hs.xfer_req), 32'd0);
    chk("ack3_data", hs.xfer_data,     32'hDEADBEEF);
    hs.xfer_ack = 1'b0;
    tick(2);
    chk("lo2_done", 32'(hs.done), 32'd0);
    tick(1);
    chk("lo3_done",  32'(hs.done),     32'd1);
    chk("lo3_ready", 32'(hs.in_ready), 32'd1);
    tick(1);
    chk("lo4_done",  32'(hs.done), 32'd0);
    chk("one_done",  32'(done_cnt - d0), 32'd1);
    chk("post_data", hs.xfer_data, 32'hDEADBEEF);
    chk("no_err",    32'(hs.err), 32'd0);

    // Back-to-back with in_valid held high
    d0 = done_cnt;
    r0 = rise_cnt;
    hs.in_valid = 1'b1;
    hs.in_data  = 32'd1;
    for (int k = 1; k <= 3; k++) begin
      wait_req($sformatf("b2b%0d_req", k), 1'b1);
      chk($sformatf("b2b%0d_data", k), hs.xfer_data, 32'(k));
      if (k < 3) hs.in_data = 32'(k + 1);
      else       hs.in_valid = 1'b0;
      tick(3);
      hs.xfer_ack = 1'b1;
      wait_req($sformatf("b2b%0d_drop", k), 1'b0);
      hs.xfer_ack = 1'b0;
      wait_done($sformatf("b2b%0d_done", k));
    end
    tick(10);
    chk("b2b_rises", 32'(rise_cnt - r0), 32'd3);
    chk("b2b_dones", 32'(done_cnt - d0), 32'd3);
    chk("b2b_data",  hs.xfer_data,       32'd3);
    chk("b2b_idle",  32'(hs.in_ready),   32'd1);

    // Ack timeout
    hs.in_valid = 1'b1;
    hs.in_data  = 32'hA5A5A5A5;
    tick(1);
    hs.in_valid = 1'b0;
    chk("tmo_req", 32'(hs.xfer_req), 32'd1);
    tick(15);
    chk("tmo_15", 32'(hs.err), 32'd0);
    tick(1);
    chk("tmo_16",     32'(hs.err),      32'd1);
    chk("tmo_reqhi",  32'(hs.xfer_req), 32'd1);
    tick(5);
    chk("tmo_sticky", 32'(hs.err), 32'd1);
    hs.xfer_ack = 1'b1;
    wait_req("tmo_late_drop", 1'b0);
    hs.xfer_ack = 1'b0;
    wait_done("tmo_late_done");
    chk("tmo_err_kept", 32'(hs.err), 32'd1);
    hs.err_clr = 1'b1;
    tick(1);
    hs.err_clr = 1'b0;
    chk("tmo_clr", 32'(hs.err), 32'd0);

    // Reset while in WAIT_LO with ack still high
    hs.in_valid = 1'b1;
    hs.in_data  = 32'h0F0F0F0F;
    wait_req("rwl_req", 1'b1);
    hs.in_valid = 1'b0;
    hs.xfer_ack = 1'b1;
    wait_req("rwl_drop", 1'b0);
    rst = 1'b1;
    #1;
    chk("rwl_req_rst",  32'(hs.xfer_req), 32'd0);
    chk("rwl_data_rst", hs.xfer_data,     32'd0);
    tick(2);
    rst = 1'b0;
    d0 = done_cnt;
    tick(6);
    chk("rwl_hold_ready", 32'(hs.in_ready), 32'd0);
    hs.xfer_ack = 1'b0;
    tick(2);
    chk("rwl_lo2_ready", 32'(hs.in_ready), 32'd0);
    tick(1);
    chk("rwl_lo3_ready", 32'(hs.in_ready), 32'd1);
    chk("rwl_no_done",   32'(done_cnt - d0), 32'd0);

    // Spurious ack pulse while idle
    d0 = done_cnt;
    r0 = rise_cnt;
    hs.xfer_ack = 1'b1;
    tick(1);
    hs.xfer_ack = 1'b0;
    tick(6);
    chk("spur_req",   32'(hs.xfer_req),   32'd0);
    chk("spur_ready", 32'(hs.in_ready),   32'd1);
    chk("spur_done",  32'(done_cnt - d0), 32'd0);
    chk("spur_rise",  32'(rise_cnt - r0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
